// File: rtl/mmio_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Package : cpu_mmio_pkg
// Brief   : Shared encodings for the memory-mapped UART transmitter.
// Rev     : 1.0  initial release
// ============================================================================
package cpu_mmio_pkg;

    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Narrows an already-aligned register word to the requested load size.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  ctrl);
        logic [31:0] r;
        r = word;
        case (ctrl)
            DM_B:    r = {{24{word[7]}}, word[7:0]};
            DM_BU:   r = {24'h0, word[7:0]};
            DM_H:    r = {{16{word[15]}}, word[15:0]};
            DM_HU:   r = {16'h0, word[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Interface : mmio_uart_tx_if
// Brief     : CPU data-memory bus as seen by an MMIO responder.
// Rev       : 1.0  initial release
// ============================================================================
interface mmio_uart_tx_if;
    logic [31:0] Address;
    logic [31:0] DataWr;
    logic        DMWr;
    logic [2:0]  DMCtrl;
    logic [31:0] DataRd;
    logic        hit;

    modport master (output Address, DataWr, DMWr, DMCtrl, input DataRd, hit);
    modport slave  (input Address, DataWr, DMWr, DMCtrl, output DataRd, hit);
endinterface
`default_nettype wire

// File: rtl/mmio_uart_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO with show-ahead head and explicit occupancy count.
// Rev    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_din,
    input  wire logic                       i_pop,
    output logic      [WIDTH-1:0]           o_dout,
    output logic                            o_full,
    output logic                            o_empty,
    output logic      [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Full is judged on the pre-edge count, so a same-cycle pop never frees room.
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end
endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module : mmio_uart_tx
// Brief  : Memory-mapped 8N1 UART transmitter with byte FIFO on the data bus.
// Rev    : 1.0  initial release
// ============================================================================
module mmio_uart_tx
    import cpu_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mmio_uart_tx_if.slave     bus,
    output logic              tx,
    output logic              tx_busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic        w_hit;
    logic        w_wr;
    logic [1:0]  w_reg;
    logic        w_byte_st;
    logic        w_push;
    logic        w_pop;
    logic [7:0]  w_fifo_dout;
    logic        w_full;
    logic        w_empty;
    logic [CW-1:0] w_count;
    logic [3:0]  w_cnt_sat;
    logic [31:0] w_word;
    logic [31:0] w_shifted;
    logic        w_unused_bits;

    logic [15:0] r_div;
    logic        r_ovf;

    uart_state_t r_state,    w_state_n;
    logic [15:0] r_baud,     w_baud_n;
    logic [2:0]  r_bit,      w_bit_n;
    logic [7:0]  r_shift,    w_shift_n;
    logic [15:0] r_div_lat,  w_div_lat_n;
    logic        r_tx,       w_tx_n;
    logic        w_baud_done;

    assign w_hit     = (bus.Address[31:4] == BASE_ADDR[31:4]);
    assign w_wr      = bus.DMWr & w_hit;
    assign w_reg     = bus.Address[3:2];
    assign w_byte_st = (bus.DMCtrl[1:0] == 2'b00);
    assign w_push    = w_wr & (w_reg == REG_TXDATA);
    assign w_unused_bits = &{1'b0, bus.DataWr[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (bus.DataWr[7:0]),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= DIV_RESET;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr && (w_reg == REG_DIV)) begin
                if (w_byte_st) r_div[7:0] <= bus.DataWr[7:0];
                else           r_div      <= bus.DataWr[15:0];
            end
            if (w_push && w_full)
                r_ovf <= 1'b1;
            else if (w_wr && (w_reg == REG_STATUS) && bus.DataWr[3])
                r_ovf <= 1'b0;
        end
    end

    assign w_cnt_sat = (int'(w_count) > 15) ? 4'hF : 4'(w_count);

    always_comb begin
        w_word = 32'h0;
        case (w_reg)
            REG_STATUS: begin
                w_word[ST_BUSY]                   = tx_busy;
                w_word[ST_FULL]                   = w_full;
                w_word[ST_EMPTY]                  = w_empty;
                w_word[ST_OVF]                    = r_ovf;
                w_word[ST_CNT_LSB+3:ST_CNT_LSB]   = w_cnt_sat;
            end
            REG_DIV: w_word = {16'h0, r_div};
            default: w_word = 32'h0;
        endcase
    end

    assign w_shifted  = w_word >> {bus.Address[1:0], 3'b000};
    assign bus.DataRd = w_hit ? load_extend(w_shifted, bus.DMCtrl) : 32'h0;
    assign bus.hit    = w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_div_lat <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_n;
            r_baud    <= w_baud_n;
            r_bit     <= w_bit_n;
            r_shift   <= w_shift_n;
            r_div_lat <= w_div_lat_n;
            r_tx      <= w_tx_n;
        end
    end

    assign w_baud_done = (r_baud == r_div_lat);

    // The divisor is sampled only when a frame starts, so mid-frame writes wait.
    always_comb begin
        w_state_n   = r_state;
        w_baud_n    = r_baud;
        w_bit_n     = r_bit;
        w_shift_n   = r_shift;
        w_div_lat_n = r_div_lat;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_n   = w_fifo_dout;
                    w_div_lat_n = r_div;
                    w_baud_n    = '0;
                    w_state_n   = START;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_baud_n  = '0;
                    w_bit_n   = '0;
                    w_state_n = DATA;
                end else begin
                    w_baud_n = r_baud + 16'd1;
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    w_baud_n  = '0;
                    w_shift_n = {1'b0, r_shift[7:1]};
                    w_bit_n   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_n = STOP;
                end else begin
                    w_baud_n = r_baud + 16'd1;
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    w_baud_n  = '0;
                    w_state_n = IDLE;
                end else begin
                    w_baud_n = r_baud + 16'd1;
                end
            end
            default: w_state_n = IDLE;
        endcase

        // Line level is registered from the next state to keep tx glitch-free.
        w_tx_n = 1'b1;
        if (w_state_n == START)     w_tx_n = 1'b0;
        else if (w_state_n == DATA) w_tx_n = w_shift_n[0];
    end

    assign tx      = r_tx;
    assign tx_busy = (r_state != IDLE) | ~w_empty;
endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_mmio_uart_tx
// Brief  : Directed self-checking bench for the MMIO UART transmitter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mmio_uart_tx;
    import cpu_mmio_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk;
    logic rst;
    logic tx;
    logic tx_busy;
    int   checks;
    int   errors;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (8),
        .DIV_RESET  (16'd433)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  ctrl;
        logic [31:0] exp_data;
        logic        exp_hit;
        string       name;
    } rd_vec_t;

    rd_vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
        @(negedge clk);
        bus.Address = a;
        bus.DataWr  = d;
        bus.DMCtrl  = c;
        bus.DMWr    = 1'b1;
        @(posedge clk);
        #1;
        bus.DMWr    = 1'b0;
        bus.Address = 32'h0;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] c,
                        input logic [31:0] exp_d, input logic exp_h, input string name);
        @(negedge clk);
        bus.Address = a;
        bus.DMCtrl  = c;
        bus.DMWr    = 1'b0;
        #1;
        chk({name, "_data"}, bus.DataRd, exp_d);
        chk({name, "_hit"}, {31'h0, bus.hit}, {31'h0, exp_h});
    endtask

    task automatic wait_start(input int max, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            @(negedge clk);
            if (tx == 1'b0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_start_timeout: got no start bit within %0d clocks, required one", tag, max);
        end
    endtask

    // Called on the first start-bit sample; checks the rest of the frame.
    task automatic frame_body(input logic [7:0] b, input int per, input string tag);
        int j;
        logic e;
        for (int k = 1; k < 10*per; k++) begin
            @(negedge clk);
            j = k / per;
            if (j == 0)      e = 1'b0;
            else if (j == 9) e = 1'b1;
            else             e = b[j-1];
            chk($sformatf("%s_c%0d", tag, k), {31'h0, tx}, {31'h0, e});
        end
    endtask

    task automatic gap_then_frame(input logic [7:0] b, input int per, input string tag);
        @(negedge clk);
        chk({tag, "_gap"}, {31'h0, tx}, 32'h1);
        @(negedge clk);
        chk({tag, "_start"}, {31'h0, tx}, 32'h0);
        frame_body(b, per, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit low_seen;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.Address = 32'h0;
        bus.DataWr  = 32'h0;
        bus.DMWr    = 1'b0;
        bus.DMCtrl  = DM_W;

        vecs[0]  = '{BASE + 32'd8,  DM_W,  32'h0000_FF80, 1'b1, "lw_div"};
        vecs[1]  = '{BASE + 32'd8,  DM_H,  32'hFFFF_FF80, 1'b1, "lh_div"};
        vecs[2]  = '{BASE + 32'd8,  DM_HU, 32'h0000_FF80, 1'b1, "lhu_div"};
        vecs[3]  = '{BASE + 32'd8,  DM_B,  32'hFFFF_FF80, 1'b1, "lb_div"};
        vecs[4]  = '{BASE + 32'd9,  DM_BU, 32'h0000_00FF, 1'b1, "lbu_div9"};
        vecs[5]  = '{BASE + 32'd9,  DM_B,  32'hFFFF_FFFF, 1'b1, "lb_div9"};
        vecs[6]  = '{BASE + 32'd10, DM_HU, 32'h0000_0000, 1'b1, "lhu_div10"};
        vecs[7]  = '{BASE + 32'd4,  DM_W,  32'h0000_0004, 1'b1, "lw_status"};
        vecs[8]  = '{BASE + 32'd5,  DM_BU, 32'h0000_0000, 1'b1, "lbu_status5"};
        vecs[9]  = '{BASE + 32'd0,  DM_W,  32'h0000_0000, 1'b1, "lw_txdata"};
        vecs[10] = '{BASE + 32'd12, DM_W,  32'h0000_0000, 1'b1, "lw_rsvd"};
        vecs[11] = '{32'h0000_2000, DM_W,  32'h0000_0000, 1'b0, "lw_miss"};
        vecs[12] = '{32'h0000_1010, DM_W,  32'h0000_0000, 1'b0, "lw_above"};
        vecs[13] = '{32'h0000_0FF8, DM_W,  32'h0000_0000, 1'b0, "lw_below"};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_tx", {31'h0, tx}, 32'h1);
        chk("rst_busy", {31'h0, tx_busy}, 32'h0);
        load(BASE + 32'd4, DM_W, 32'h0000_0004, 1'b1, "rst_status");
        load(BASE + 32'd8, DM_W, 32'd433, 1'b1, "rst_div");

        // Read path table
        store(BASE + 32'd8, 32'h0000_FF80, DM_W);
        foreach (vecs[i]) load(vecs[i].addr, vecs[i].ctrl, vecs[i].exp_data, vecs[i].exp_hit, vecs[i].name);

        // Store sizes into DIVISOR
        store(BASE + 32'd8, 32'hAAAA_AA12, DM_B);
        load(BASE + 32'd8, DM_HU, 32'h0000_FF12, 1'b1, "sb_div");
        store(BASE + 32'd10, 32'h5555_ABCD, DM_H);
        load(BASE + 32'd8, DM_W, 32'h0000_ABCD, 1'b1, "sh_div");
        store(BASE + 32'd8, 32'h1234_0003, DM_W);
        load(BASE + 32'd8, DM_W, 32'h0000_0003, 1'b1, "sw_div");

        // Single frame 0x55, 4-clock bits, exact latency
        store(BASE + 32'd0, 32'h0000_0055, DM_B);
        @(negedge clk);
        chk("f1_lat_tx", {31'h0, tx}, 32'h1);
        chk("f1_lat_busy", {31'h0, tx_busy}, 32'h1);
        @(negedge clk);
        chk("f1_start", {31'h0, tx}, 32'h0);
        frame_body(8'h55, 4, "f1");
        @(negedge clk);
        chk("f1_end_busy", {31'h0, tx_busy}, 32'h0);
        chk("f1_end_tx", {31'h0, tx}, 32'h1);

        // Overflow: one byte in flight, eight queued, ninth dropped
        fork
            begin
                wait_start(20, "ov");
                frame_body(8'hC3, 4, "ovC3");
                for (int i = 0; i < 8; i++) gap_then_frame(8'(i), 4, $sformatf("ov%0d", i));
                @(negedge clk);
                chk("ov_end_busy", {31'h0, tx_busy}, 32'h0);
                low_seen = 1'b0;
                repeat (60) begin
                    @(negedge clk);
                    if (tx == 1'b0) low_seen = 1'b1;
                end
                chk("ov_no_ninth", {31'h0, low_seen}, 32'h0);
            end
            begin
                store(BASE, 32'h0000_00C3, DM_W);
                for (int i = 0; i < 9; i++) store(BASE, 32'(i), DM_W);
                load(BASE + 32'd4, DM_W, 32'h0000_008B, 1'b1, "ov_status");
                store(BASE + 32'd4, 32'h0000_0008, DM_W);
                load(BASE + 32'd4, DM_W, 32'h0000_0083, 1'b1, "ov_cleared");
            end
        join
        load(BASE + 32'd4, DM_W, 32'h0000_0004, 1'b1, "ov_final_status");

        // DIVISOR change mid-frame applies to the next frame only
        fork
            begin
                wait_start(20, "dv");
                frame_body(8'h3C, 4, "dv1");
                gap_then_frame(8'h5A, 8, "dv2");
                @(negedge clk);
                chk("dv_end_busy", {31'h0, tx_busy}, 32'h0);
            end
            begin
                store(BASE, 32'h0000_003C, DM_B);
                store(BASE, 32'h0000_005A, DM_B);
                repeat (12) @(negedge clk);
                store(BASE + 32'd8, 32'h0000_0007, DM_W);
            end
        join

        // Reset during bit 3 with three bytes queued
        store(BASE + 32'd8, 32'h0000_0003, DM_W);
        store(BASE, 32'h0000_0011, DM_B);
        store(BASE, 32'h0000_0022, DM_B);
        store(BASE, 32'h0000_0033, DM_B);
        store(BASE, 32'h0000_0044, DM_B);
        repeat (15) @(negedge clk);
        chk("mr_bit3", {31'h0, tx}, 32'h0);
        chk("mr_busy_pre", {31'h0, tx_busy}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mr_tx", {31'h0, tx}, 32'h1);
        chk("mr_busy", {31'h0, tx_busy}, 32'h0);
        load(BASE + 32'd4, DM_W, 32'h0000_0004, 1'b1, "mr_status");
        load(BASE + 32'd8, DM_W, 32'd433, 1'b1, "mr_div");
        low_seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (tx == 1'b0) low_seen = 1'b1;
        end
        chk("mr_line_idle", {31'h0, low_seen}, 32'h0);

        // Stores to reserved offset and outside the window are ignored
        store(BASE + 32'd12, 32'h0000_0041, DM_W);
        store(32'h0000_2000, 32'h0000_0041, DM_W);
        store(32'h0000_2004, 32'h0000_0008, DM_W);
        low_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (tx == 1'b0 || tx_busy == 1'b1) low_seen = 1'b1;
        end
        chk("ign_line_idle", {31'h0, low_seen}, 32'h0);
        load(BASE + 32'd4, DM_W, 32'h0000_0004, 1'b1, "ign_status");
        load(BASE + 32'd12, DM_W, 32'h0000_0000, 1'b1, "ign_rsvd");
        load(BASE + 32'd8, DM_W, 32'd433, 1'b1, "ign_div");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
